multi_channel_input_synchronizer: RTL and testbench

- Brings CHANNELS independent asynchronous multi-bit input buses into the `clk` domain.
- Each channel passes through a SYNC_STAGES-deep flop chain, then a stability filter.
- The filter commits a new value only after it has been seen unchanged for STABLE_CYCLES consecutive cycles, and flags that commit with a one-cycle strobe.
- Used for slow external/control buses, e.g. DIP switches, host status words and configuration buses, where bus-level coherence and glitch rejection are required.

---
 rtl/multi_channel_input_synchronizer_pkg.sv | 19 +
 rtl/multi_channel_input_synchronizer_if.sv | 23 ++
 rtl/multi_channel_input_synchronizer_channel.sv | 105 ++++++++++
 rtl/multi_channel_input_synchronizer.sv | 35 +++
 tb/tb_multi_channel_input_synchronizer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_input_synchronizer_pkg.sv
// Shared types and helpers for the multi-channel input synchronizer.
// Combinational only; no latency and no backpressure.
package multi_channel_input_synchronizer_pkg;

  typedef enum logic {
    STATE_STABLE   = 1'b0,
    STATE_SETTLING = 1'b1
  } sync_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_channel_input_synchronizer_if.sv
// Bundles the per-channel data, strobes and glitch controls.
// Wiring only; no latency, and the inputs cannot be backpressured.
interface multi_channel_input_synchronizer_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8
);
  logic [CHANNELS*DATA_WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]            glitch_clear;
  wire  [CHANNELS*DATA_WIDTH-1:0] data_out;
  wire  [CHANNELS-1:0]            valid_out;
  wire  [CHANNELS-1:0]            settling;
  wire  [CHANNELS-1:0]            glitch_flag;

  modport master (
    output data_in, glitch_clear,
    input  data_out, valid_out, settling, glitch_flag
  );

  modport slave (
    input  data_in, glitch_clear,
    output data_out, valid_out, settling, glitch_flag
  );
endinterface

// File: rtl/multi_channel_input_synchronizer_channel.sv
// One channel: flop-chain synchronizer followed by a stability filter.
// Commits SYNC_STAGES+STABLE_CYCLES edges after a held change; no backpressure.
module input_sync_channel
  import multi_channel_input_synchronizer_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    SYNC_STAGES   = 2,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  glitch_clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  settling,
  output logic                  glitch_flag
);

  localparam int                CNT_W    = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] samp;

  sync_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] cand, cand_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  valid_nxt;
  logic                  glitch_set;
  logic                  glitch_nxt;

  // Plain flop chain: nothing may sit between stages or metastability leaks through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
    end else begin
      sync_q[0] <= data_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign samp = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    data_nxt   = data_out;
    valid_nxt  = 1'b0;
    glitch_set = 1'b0;
    case (state)
      STATE_STABLE: begin
        if (samp != data_out) begin
          cand_nxt  = samp;
          cnt_nxt   = CNT_ONE;
          state_nxt = STATE_SETTLING;
        end
      end
      STATE_SETTLING: begin
        if (samp != cand) begin
          cand_nxt   = samp;
          cnt_nxt    = CNT_ONE;
          glitch_set = 1'b1;
        end else if (cnt < CNT_LAST) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // A candidate equal to data_out means the input reverted: settle silently.
          if (cand != data_out) begin
            data_nxt  = cand;
            valid_nxt = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = STATE_STABLE;
        end
      end
      default: state_nxt = STATE_STABLE;
    endcase
    glitch_nxt = glitch_set | (glitch_flag & ~glitch_clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STATE_STABLE;
      cand        <= RESET_VALUE;
      cnt         <= '0;
      data_out    <= RESET_VALUE;
      valid_out   <= 1'b0;
      glitch_flag <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      glitch_flag <= glitch_nxt;
    end
  end

  assign settling = (state == STATE_SETTLING);

endmodule

// File: rtl/multi_channel_input_synchronizer.sv
// CHANNELS independent glitch-filtered synchronizers sharing one packed bus.
// Latency SYNC_STAGES+STABLE_CYCLES edges per channel; inputs are never backpressured.
module multi_channel_input_synchronizer
  import multi_channel_input_synchronizer_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    CHANNELS      = 4,
  parameter int                    SYNC_STAGES   = 2,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  multi_channel_input_synchronizer_if.slave bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    input_sync_channel #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VALUE  (RESET_VALUE)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .data_in     (bus.data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .glitch_clear(bus.glitch_clear[c]),
      .data_out    (bus.data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .valid_out   (bus.valid_out[c]),
      .settling    (bus.settling[c]),
      .glitch_flag (bus.glitch_flag[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_input_synchronizer.sv
// Randomized and directed bench against a run-length reference model.
module tb_multi_channel_input_synchronizer;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_channel_input_synchronizer_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

  multi_channel_input_synchronizer #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .RESET_VALUE('0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pipeline of raw samples plus run length of the synchronized value.
  logic [DW-1:0] din      [CH];
  logic [CH-1:0] clr;
  logic [DW-1:0] m_hist   [CH][SS];
  logic [DW-1:0] m_prev   [CH];
  logic [DW-1:0] m_dout   [CH];
  int            m_run    [CH];
  logic          m_vld    [CH];
  logic          m_glitch [CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) m_hist[c][k] = '0;
      m_prev[c]   = '0;
      m_dout[c]   = '0;
      m_run[c]    = ST;
      m_vld[c]    = 1'b0;
      m_glitch[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] samp;
    logic          gset;
    for (int c = 0; c < CH; c++) begin
      samp = m_hist[c][SS-1];
      for (int k = SS-1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = din[c];
      gset     = 1'b0;
      m_vld[c] = 1'b0;
      if (samp != m_prev[c]) begin
        if (m_run[c] < ST) gset = 1'b1;
        m_run[c] = 1;
      end else if (m_run[c] < ST) begin
        m_run[c]++;
        if (m_run[c] == ST && samp != m_dout[c]) begin
          m_dout[c] = samp;
          m_vld[c]  = 1'b1;
        end
      end
      m_prev[c]   = samp;
      m_glitch[c] = gset | (m_glitch[c] & ~clr[c]);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      check_val($sformatf("dout%0d", c),   32'(bus.data_out[c*DW +: DW]), 32'(m_dout[c]));
      check_val($sformatf("vld%0d", c),    32'(bus.valid_out[c]),        32'(m_vld[c]));
      check_val($sformatf("settle%0d", c), 32'(bus.settling[c]),         32'(m_run[c] < ST));
      check_val($sformatf("glitch%0d", c), 32'(bus.glitch_flag[c]),      32'(m_glitch[c]));
    end
  endtask

  task automatic step();
    for (int c = 0; c < CH; c++) bus.data_in[c*DW +: DW] = din[c];
    bus.glitch_clear = clr;
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int pulses;
  int pulse_at;
  int hold [CH];

  initial begin
    for (int c = 0; c < CH; c++) din[c] = '0;
    clr     = '0;
    reset_n = 1'b0;
    bus.data_in      = '0;
    bus.glitch_clear = '0;
    model_reset();
    #1;
    check_all();

    // Reset then idle
    steps(3);
    reset_n = 1'b1;
    steps(20);
    check_val("idle_dout", 32'(bus.data_out), 32'h0);
    check_val("idle_glitch", 32'(bus.glitch_flag), 32'h0);

    // Single change on channel 0
    din[0] = 8'hA5;
    steps(2);
    check_val("single_settle_e2", 32'(bus.settling[0]), 32'h0);
    step();
    check_val("single_settle_e3", 32'(bus.settling[0]), 32'h1);
    steps(2);
    check_val("single_dout_e5", 32'(bus.data_out[7:0]), 32'h00);
    step();
    check_val("single_dout_e6", 32'(bus.data_out[7:0]), 32'hA5);
    check_val("single_vld_e6", 32'(bus.valid_out), 32'h1);
    step();
    check_val("single_vld_e7", 32'(bus.valid_out[0]), 32'h0);
    steps(3);

    // Glitch rejection on channel 1
    din[1] = 8'h3C;
    steps(2);
    din[1] = 8'h00;
    steps(10);
    check_val("glitch_dout1", 32'(bus.data_out[15:8]), 32'h00);
    check_val("glitch_flag1", 32'(bus.glitch_flag[1]), 32'h1);
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check_val("glitch_clr1", 32'(bus.glitch_flag[1]), 32'h0);
    steps(2);

    // Bouncing input on channel 2, final toggle lands on 0x11 before the hold of 0x22
    for (int i = 0; i < 10; i++) begin
      din[2] = (i % 2 == 0) ? 8'h22 : 8'h11;
      step();
    end
    din[2]   = 8'h22;
    pulses   = 0;
    pulse_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.valid_out[2]) begin
        pulses++;
        pulse_at = i;
      end
    end
    check_val("bounce_pulses", 32'(pulses), 32'd1);
    check_val("bounce_at", 32'(pulse_at), 32'd6);
    check_val("bounce_dout", 32'(bus.data_out[23:16]), 32'h22);
    check_val("bounce_glitch", 32'(bus.glitch_flag[2]), 32'h1);

    // All channels change in the same cycle
    din[0] = 8'h01; din[1] = 8'h02; din[2] = 8'h03; din[3] = 8'h04;
    pulse_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.valid_out == 4'hF) pulse_at = i;
    end
    check_val("all_at", 32'(pulse_at), 32'd6);
    check_val("all_dout", 32'(bus.data_out), 32'h04030201);

    // Reset mid-settle on channel 3
    din[3] = 8'hFF;
    steps(4);
    check_val("rst_pre_settle3", 32'(bus.settling[3]), 32'h1);
    for (int c = 0; c < CH; c++) din[c] = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_dout", 32'(bus.data_out), 32'h0);
    check_val("rst_settle", 32'(bus.settling), 32'h0);
    check_val("rst_glitch", 32'(bus.glitch_flag), 32'h0);
    steps(2);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.valid_out != '0) pulses++;
    end
    check_val("rst_no_vld", 32'(pulses), 32'd0);

    // Randomized traffic with random holds and glitch clears
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          din[c]  = ($urandom_range(0, 3) == 0) ? 8'(c) : 8'($urandom);
          hold[c] = $urandom_range(1, 12);
        end else begin
          hold[c]--;
        end
      end
      clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
